// File: rtl/memory_access_cycle_pkg.sv
// Shared constants for the MEM stage: FSM state encodings, load/store size codes,
// the stage control bundle and the misalignment predicate.
package memory_access_cycle_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [2:0] F3_B = 3'b000;
  localparam logic [2:0] F3_H = 3'b001;
  localparam logic [2:0] F3_W = 3'b010;

  typedef struct packed {
    logic valid;
    logic regwrite;
    logic memread;
    logic memwrite;
    logic jtype;
  } mem_ctrl_t;

  // Halfwords need an even address, words a multiple of four; bit 2 (unsigned) is ignored.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    case ({1'b0, funct3[1:0]})
      F3_H:    mis = addr_lo[0];
      F3_W:    mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/memory_access_cycle_store_aligner.sv
// Store lane steering: replicates byte/half data across the word and builds byte enables.
module memory_access_cycle_store_aligner
  import memory_access_cycle_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb
);

  // Size decode; anything that is not B or H is treated as a full word.
  always_comb begin
    wdata = data;
    wstrb = 4'hF;
    case ({1'b0, funct3[1:0]})
      F3_B: begin
        wdata = {4{data[7:0]}};
        wstrb = 4'b0001 << addr_lo;
      end
      F3_H: begin
        wdata = {2{data[15:0]}};
        wstrb = 4'b0011 << {addr_lo[1], 1'b0};
      end
      default: begin
        wdata = data;
        wstrb = 4'hF;
      end
    endcase
  end

endmodule

// File: rtl/memory_access_cycle.sv
// MEM pipeline stage: stage register, req/gnt/rvalid data-memory FSM and *M outputs to writeback.
// Define MISALIGN_TRAP_EN to trap misaligned H/W accesses (no request, MisalignM pulse).
module memory_access_cycle
  import memory_access_cycle_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int SEL_W = 6,
  parameter int RA_W  = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ValidE,
  input  logic             RegWriteE,
  input  logic             MemReadE,
  input  logic             MemWriteE,
  input  logic             JtypeE,
  input  logic [XLEN-1:0]  ALUOutE,
  input  logic [XLEN-1:0]  StoreDataE,
  input  logic [SEL_W-1:0] ALUSelectE,
  input  logic [RA_W-1:0]  WriteAddressE,
  input  logic             FlushM,
  output logic             StallM,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [XLEN-1:0]  dmem_wdata,
  output logic [3:0]       dmem_wstrb,
  input  logic             dmem_gnt,
  input  logic             dmem_rvalid,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             RegWriteM,
  output logic             MemReadM,
  output logic             JtypeM,
  output logic [XLEN-1:0]  ALUOutM,
  output logic [XLEN-1:0]  DataMemOutM,
`ifdef MISALIGN_TRAP_EN
  output logic             MisalignM,
`endif
  output logic [SEL_W-1:0] ALUSelectM,
  output logic [RA_W-1:0]  WriteAddressM
);

  logic [1:0]       state_q, state_d;
  mem_ctrl_t        ctrl_q, ctrl_d;
  logic [XLEN-1:0]  alu_q, alu_d, sdata_q, sdata_d, rdata_q, rdata_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [RA_W-1:0]  rd_q, rd_d;
  logic             kill_q, kill_d;
  logic             stall_s, mem_op_e_s;
  logic [31:0]      al_wdata_s;
  logic [3:0]       al_wstrb_s;
`ifdef MISALIGN_TRAP_EN
  logic             misalign_q, misalign_d, mis_e_s;
`endif

  // Next-state for the FSM and stage register; capture only happens in IDLE/DONE.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    alu_d      = alu_q;
    sdata_d    = sdata_q;
    sel_d      = sel_q;
    rd_d       = rd_q;
    rdata_d    = rdata_q;
    kill_d     = kill_q;
    stall_s    = (state_q == ST_REQ) | (state_q == ST_RESP);
    mem_op_e_s = ValidE & (MemReadE | MemWriteE) & ~FlushM;
`ifdef MISALIGN_TRAP_EN
    misalign_d = misalign_q;
    mis_e_s    = mem_op_e_s & is_misaligned(ALUSelectE[2:0], ALUOutE[1:0]);
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        alu_d   = ALUOutE;
        sdata_d = StoreDataE;
        sel_d   = ALUSelectE;
        rd_d    = WriteAddressE;
        kill_d  = 1'b0;
        if (ValidE && !FlushM) begin
          ctrl_d = '{valid: 1'b1, regwrite: RegWriteE, memread: MemReadE,
                     memwrite: MemWriteE, jtype: JtypeE};
        end else begin
          ctrl_d = '0;
        end
`ifdef MISALIGN_TRAP_EN
        misalign_d = mis_e_s;
        if (mis_e_s) begin
          state_d = ST_DONE;
        end else if (mem_op_e_s) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
`else
        if (mem_op_e_s) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
`endif
      end
      ST_REQ: begin
        // Once granted the access cannot be recalled; a flush only discards its result.
        if (dmem_gnt) begin
          if (ctrl_q.memwrite) begin
            if (FlushM) begin
              state_d = ST_IDLE;
              ctrl_d  = '0;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            state_d = ST_RESP;
            kill_d  = FlushM;
          end
        end else if (FlushM) begin
          state_d = ST_IDLE;
          ctrl_d  = '0;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_RESP: begin
        if (dmem_rvalid) begin
          if (kill_q || FlushM) begin
            state_d = ST_IDLE;
            ctrl_d  = '0;
          end else begin
            rdata_d = dmem_rdata;
            state_d = ST_DONE;
          end
        end else begin
          kill_d = kill_q | FlushM;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ctrl_d  = '0;
      end
    endcase
  end

  // Stage and FSM registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= '0;
      alu_q      <= '0;
      sdata_q    <= '0;
      sel_q      <= '0;
      rd_q       <= '0;
      rdata_q    <= '0;
      kill_q     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      alu_q      <= alu_d;
      sdata_q    <= sdata_d;
      sel_q      <= sel_d;
      rd_q       <= rd_d;
      rdata_q    <= rdata_d;
      kill_q     <= kill_d;
`ifdef MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  memory_access_cycle_store_aligner u_store_aligner (
    .funct3  (sel_q[2:0]),
    .addr_lo (alu_q[1:0]),
    .data    (sdata_q[31:0]),
    .wdata   (al_wdata_s),
    .wstrb   (al_wstrb_s)
  );

  assign StallM        = stall_s;
  assign dmem_req      = (state_q == ST_REQ);
  assign dmem_we       = ctrl_q.memwrite;
  assign dmem_addr     = {alu_q[XLEN-1:2], 2'b00};
  assign dmem_wdata    = al_wdata_s;
  assign dmem_wstrb    = ctrl_q.memwrite ? al_wstrb_s : 4'b0000;
  assign MemReadM      = ctrl_q.memread;
  assign JtypeM        = ctrl_q.jtype;
  assign ALUOutM       = alu_q;
  assign DataMemOutM   = rdata_q;
  assign ALUSelectM    = sel_q;
  assign WriteAddressM = rd_q;
`ifdef MISALIGN_TRAP_EN
  assign MisalignM     = misalign_q;
  assign RegWriteM     = ctrl_q.valid & ctrl_q.regwrite & ~misalign_q &
                         ((state_q == ST_IDLE) | (state_q == ST_DONE));
`else
  assign RegWriteM     = ctrl_q.valid & ctrl_q.regwrite &
                         ((state_q == ST_IDLE) | (state_q == ST_DONE));
`endif

endmodule

// File: tb/tb_memory_access_cycle.sv
// Scoreboard bench for memory_access_cycle: expectations are queued at issue and
// popped when the stage presents the result (writeback or memory request).
module tb_memory_access_cycle;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ValidE, RegWriteE, MemReadE, MemWriteE, JtypeE, FlushM;
  logic [31:0] ALUOutE, StoreDataE;
  logic [5:0]  ALUSelectE;
  logic [4:0]  WriteAddressE;
  logic        StallM, dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        RegWriteM, MemReadM, JtypeM;
  logic [31:0] ALUOutM, DataMemOutM;
  logic [5:0]  ALUSelectM;
  logic [4:0]  WriteAddressM;
`ifdef MISALIGN_TRAP_EN
  logic        MisalignM;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] v;
    logic [4:0]  rd;
    logic [3:0]  strb;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  memory_access_cycle dut (
    .clk(clk), .reset_n(reset_n), .ValidE(ValidE), .RegWriteE(RegWriteE),
    .MemReadE(MemReadE), .MemWriteE(MemWriteE), .JtypeE(JtypeE), .ALUOutE(ALUOutE),
    .StoreDataE(StoreDataE), .ALUSelectE(ALUSelectE), .WriteAddressE(WriteAddressE),
    .FlushM(FlushM), .StallM(StallM), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .RegWriteM(RegWriteM), .MemReadM(MemReadM), .JtypeM(JtypeM), .ALUOutM(ALUOutM),
    .DataMemOutM(DataMemOutM),
`ifdef MISALIGN_TRAP_EN
    .MisalignM(MisalignM),
`endif
    .ALUSelectM(ALUSelectM), .WriteAddressM(WriteAddressM)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_e;
    ValidE = 1'b0; RegWriteE = 1'b0; MemReadE = 1'b0; MemWriteE = 1'b0; JtypeE = 1'b0;
    ALUOutE = 32'h0; StoreDataE = 32'h0; ALUSelectE = 6'h0; WriteAddressE = 5'h0;
  endtask

  task automatic drive_e(input logic rw, input logic ld, input logic st, input logic [31:0] addr,
                         input logic [31:0] data, input logic [5:0] sel, input logic [4:0] rd);
    ValidE = 1'b1; RegWriteE = rw; MemReadE = ld; MemWriteE = st; JtypeE = 1'b0;
    ALUOutE = addr; StoreDataE = data; ALUSelectE = sel; WriteAddressE = rd;
  endtask

  task automatic test_reset;
    checks++; if (RegWriteM !== 1'b0) begin failures++; $display("FAIL rst_regwrite got=%0b exp=0", RegWriteM); end
    checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%0b exp=0", dmem_req); end
    checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0b exp=0", StallM); end
    checks++; if (ALUOutM !== 32'h0) begin failures++; $display("FAIL rst_aluout got=%h exp=0", ALUOutM); end
    checks++; if (DataMemOutM !== 32'h0) begin failures++; $display("FAIL rst_dataout got=%h exp=0", DataMemOutM); end
  endtask

  task automatic test_alu;
    exp_t e;
    drive_e(1'b1, 1'b0, 1'b0, 32'h12345678, 32'h0, 6'h00, 5'd5);
    sb.push_back('{a: 32'h12345678, v: 32'h0, rd: 5'd5, strb: 4'h0});
    tick;
    clear_e;
    e = sb.pop_front();
    checks++; if (ALUOutM !== e.a) begin failures++; $display("FAIL alu_out got=%h exp=%h", ALUOutM, e.a); end
    checks++; if (WriteAddressM !== e.rd) begin failures++; $display("FAIL alu_rd got=%0d exp=%0d", WriteAddressM, e.rd); end
    checks++; if (RegWriteM !== 1'b1) begin failures++; $display("FAIL alu_regwrite got=%0b exp=1", RegWriteM); end
    checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL alu_stall got=%0b exp=0", StallM); end
    tick;
    checks++; if (RegWriteM !== 1'b0) begin failures++; $display("FAIL alu_bubble got=%0b exp=0", RegWriteM); end
  endtask

  task automatic test_load;
    exp_t e;
    drive_e(1'b1, 1'b1, 1'b0, 32'h00000100, 32'h0, 6'b000010, 5'd7);
    sb.push_back('{a: 32'h00000100, v: 32'hABCD1234, rd: 5'd7, strb: 4'h0});
    tick;
    clear_e;
    checks++; if (dmem_req !== 1'b1) begin failures++; $display("FAIL ld_req got=%0b exp=1", dmem_req); end
    checks++; if (dmem_addr !== 32'h100) begin failures++; $display("FAIL ld_addr got=%h exp=00000100", dmem_addr); end
    checks++; if ({dmem_we, dmem_wstrb} !== 5'b0) begin failures++; $display("FAIL ld_we_strb got=%b exp=00000", {dmem_we, dmem_wstrb}); end
    checks++; if ({StallM, RegWriteM} !== 2'b10) begin failures++; $display("FAIL ld_req_stall got=%b exp=10", {StallM, RegWriteM}); end
    dmem_gnt = 1'b1;
    tick;
    dmem_gnt = 1'b0;
    checks++; if ({dmem_req, StallM, RegWriteM} !== 3'b010) begin failures++; $display("FAIL ld_resp got=%b exp=010", {dmem_req, StallM, RegWriteM}); end
    dmem_rvalid = 1'b1; dmem_rdata = 32'hABCD1234;
    tick;
    dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    e = sb.pop_front();
    checks++; if (DataMemOutM !== e.v) begin failures++; $display("FAIL ld_data got=%h exp=%h", DataMemOutM, e.v); end
    checks++; if ({RegWriteM, MemReadM, StallM} !== 3'b110) begin failures++; $display("FAIL ld_done got=%b exp=110", {RegWriteM, MemReadM, StallM}); end
    checks++; if (WriteAddressM !== e.rd) begin failures++; $display("FAIL ld_rd got=%0d exp=%0d", WriteAddressM, e.rd); end
    // Capture a new ALU op in the DONE cycle.
    drive_e(1'b1, 1'b0, 1'b0, 32'hCAFE0000, 32'h0, 6'h00, 5'd3);
    sb.push_back('{a: 32'hCAFE0000, v: 32'hABCD1234, rd: 5'd3, strb: 4'h0});
    tick;
    clear_e;
    e = sb.pop_front();
    checks++; if ({RegWriteM, ALUOutM} !== {1'b1, e.a}) begin failures++; $display("FAIL b2b_alu got=%b/%h exp=1/%h", RegWriteM, ALUOutM, e.a); end
    checks++; if (DataMemOutM !== e.v) begin failures++; $display("FAIL b2b_hold got=%h exp=%h", DataMemOutM, e.v); end
  endtask

  task automatic test_store;
    logic [31:0] addr_t [4] = '{32'h203, 32'h202, 32'h300, 32'h001};
    logic [31:0] data_t [4] = '{32'h000000EF, 32'h1234BEEF, 32'h89ABCDEF, 32'h0000005A};
    logic [5:0]  sel_t  [4] = '{6'b000000, 6'b000001, 6'b000010, 6'b000000};
    logic [31:0] wd_t   [4] = '{32'hEFEFEFEF, 32'hBEEFBEEF, 32'h89ABCDEF, 32'h5A5A5A5A};
    logic [3:0]  st_t   [4] = '{4'b1000, 4'b1100, 4'b1111, 4'b0010};
    logic [31:0] wa_t   [4] = '{32'h200, 32'h200, 32'h300, 32'h000};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      drive_e(1'b0, 1'b0, 1'b1, addr_t[i], data_t[i], sel_t[i], 5'd0);
      sb.push_back('{a: wa_t[i], v: wd_t[i], rd: 5'd0, strb: st_t[i]});
      tick;
      clear_e;
      for (int w = 0; w < 5 && dmem_req !== 1'b1; w++) tick;
      checks++; if (dmem_req !== 1'b1) begin failures++; $display("FAIL st%0d_req_timeout got=%0b exp=1", i, dmem_req); end
      e = sb.pop_front();
      checks++; if (dmem_addr !== e.a) begin failures++; $display("FAIL st%0d_addr got=%h exp=%h", i, dmem_addr, e.a); end
      checks++; if (dmem_wdata !== e.v) begin failures++; $display("FAIL st%0d_wdata got=%h exp=%h", i, dmem_wdata, e.v); end
      checks++; if ({dmem_we, dmem_wstrb} !== {1'b1, e.strb}) begin failures++; $display("FAIL st%0d_we_strb got=%b exp=1%b", i, {dmem_we, dmem_wstrb}, e.strb); end
      dmem_gnt = 1'b1;
      tick;
      dmem_gnt = 1'b0;
      checks++; if ({dmem_req, StallM, RegWriteM} !== 3'b000) begin failures++; $display("FAIL st%0d_done got=%b exp=000", i, {dmem_req, StallM, RegWriteM}); end
    end
  endtask

  task automatic test_delayed_gnt;
    exp_t e;
    drive_e(1'b1, 1'b1, 1'b0, 32'h00000400, 32'h0, 6'b000010, 5'd9);
    sb.push_back('{a: 32'h00000400, v: 32'h0BADF00D, rd: 5'd9, strb: 4'h0});
    tick;
    clear_e;
    for (int c = 0; c < 3; c++) begin
      checks++; if ({dmem_req, StallM, RegWriteM} !== 3'b110 || dmem_addr !== 32'h400) begin
        failures++; $display("FAIL dly_hold%0d got=%b/%h exp=110/00000400", c, {dmem_req, StallM, RegWriteM}, dmem_addr); end
      tick;
    end
    dmem_gnt = 1'b1;
    tick;
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0BADF00D;
    tick;
    dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    for (int w = 0; w < 8 && RegWriteM !== 1'b1; w++) tick;
    checks++; if (RegWriteM !== 1'b1) begin failures++; $display("FAIL dly_wb_timeout got=%0b exp=1", RegWriteM); end
    e = sb.pop_front();
    checks++; if ({DataMemOutM, WriteAddressM} !== {e.v, e.rd}) begin failures++; $display("FAIL dly_data got=%h/%0d exp=%h/%0d", DataMemOutM, WriteAddressM, e.v, e.rd); end
    tick;
  endtask

  task automatic test_flush;
    exp_t e;
    // Flush while waiting for rvalid: the response is consumed and dropped.
    drive_e(1'b1, 1'b1, 1'b0, 32'h00000500, 32'h0, 6'b000010, 5'd4);
    tick;
    clear_e;
    dmem_gnt = 1'b1;
    tick;
    dmem_gnt = 1'b0;
    FlushM = 1'b1;
    tick;
    FlushM = 1'b0;
    checks++; if ({StallM, RegWriteM} !== 2'b10) begin failures++; $display("FAIL fl_resp_hold got=%b exp=10", {StallM, RegWriteM}); end
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
    tick;
    dmem_rvalid = 1'b0;
    checks++; if ({StallM, RegWriteM} !== 2'b00) begin failures++; $display("FAIL fl_resp_end got=%b exp=00", {StallM, RegWriteM}); end
    checks++; if (DataMemOutM !== 32'h0BADF00D) begin failures++; $display("FAIL fl_resp_data got=%h exp=0badf00d", DataMemOutM); end
    // Stray rvalid in IDLE is ignored.
    dmem_rvalid = 1'b1; dmem_rdata = 32'h11111111;
    tick;
    dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    checks++; if (DataMemOutM !== 32'h0BADF00D) begin failures++; $display("FAIL stray_rvalid got=%h exp=0badf00d", DataMemOutM); end
    // Flush before grant drops the request.
    drive_e(1'b1, 1'b1, 1'b0, 32'h00000600, 32'h0, 6'b000010, 5'd6);
    tick;
    clear_e;
    FlushM = 1'b1;
    tick;
    FlushM = 1'b0;
    checks++; if ({dmem_req, StallM, RegWriteM} !== 3'b000) begin failures++; $display("FAIL fl_req got=%b exp=000", {dmem_req, StallM, RegWriteM}); end
    drive_e(1'b1, 1'b0, 1'b0, 32'h00000777, 32'h0, 6'h00, 5'd11);
    sb.push_back('{a: 32'h00000777, v: 32'h0, rd: 5'd11, strb: 4'h0});
    tick;
    clear_e;
    e = sb.pop_front();
    checks++; if ({RegWriteM, ALUOutM, WriteAddressM} !== {1'b1, e.a, e.rd}) begin failures++; $display("FAIL fl_after got=%b/%h/%0d exp=1/%h/%0d", RegWriteM, ALUOutM, WriteAddressM, e.a, e.rd); end
  endtask

  task automatic test_reset_in_req;
    drive_e(1'b1, 1'b1, 1'b0, 32'h00000700, 32'h0, 6'b000010, 5'd8);
    tick;
    clear_e;
    checks++; if (dmem_req !== 1'b1) begin failures++; $display("FAIL rreq_pre got=%0b exp=1", dmem_req); end
    reset_n = 1'b0;
    #1;
    checks++; if ({dmem_req, StallM, RegWriteM} !== 3'b000) begin failures++; $display("FAIL rreq_async got=%b exp=000", {dmem_req, StallM, RegWriteM}); end
    checks++; if (DataMemOutM !== 32'h0) begin failures++; $display("FAIL rreq_data got=%h exp=0", DataMemOutM); end
    tick;
    reset_n = 1'b1;
    tick;
    checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL rreq_post got=%0b exp=0", dmem_req); end
  endtask

`ifdef MISALIGN_TRAP_EN
  task automatic test_misalign;
    drive_e(1'b1, 1'b1, 1'b0, 32'h00000102, 32'h0, 6'b000010, 5'd2);
    tick;
    clear_e;
    checks++; if ({dmem_req, MisalignM, RegWriteM, StallM} !== 4'b0100) begin failures++; $display("FAIL misalign got=%b exp=0100", {dmem_req, MisalignM, RegWriteM, StallM}); end
    tick;
    checks++; if ({dmem_req, MisalignM} !== 2'b00) begin failures++; $display("FAIL misalign_clr got=%b exp=00", {dmem_req, MisalignM}); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    FlushM = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    clear_e;
    ValidE = 1'b1; ALUOutE = 32'hFFFFFFFF; RegWriteE = 1'b1; MemReadE = 1'b1;
    tick;
    tick;
    test_reset;
    clear_e;
    reset_n = 1'b1;
    tick;
    test_alu;
    test_load;
    test_store;
    test_delayed_gnt;
    test_flush;
    test_reset_in_req;
`ifdef MISALIGN_TRAP_EN
    test_misalign;
`endif
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL sb_empty got=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
